wash_phase_sequencer: RTL and testbench

// - Sequences one wash program: WASH -> DRAIN_W -> SPIN -> RINSE -> DRAIN_R -> FINAL_SPIN -> DONE.
// - Skips phases the selected program disables.
// - Sits under the top-level run/pause/error FSM:
//   - its run output gates this block;
//   - phase feeds the door-safety check (codes 3 and 7 are spin phases);
//   - hadFinish drives the FSM into its finish state.
// - Drives the motor and drain enables, plus the remaining-time display counters.

---
 rtl/wash_phase_sequencer_pkg.sv | 62 ++++++
 rtl/wash_phase_sequencer_tick_down_counter.sv | 38 +++
 rtl/wash_phase_sequencer.sv | 140 ++++++++++++++
 tb/tb_wash_phase_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/wash_phase_sequencer_pkg.sv
// Phase codes, mode bit positions and walk-order helpers shared by the wash sequencer
// and by the top-level run/pause/error FSM (spin phases are codes 3 and 7).
package wash_phase_sequencer_pkg;

  localparam logic [2:0] PH_IDLE    = 3'd0;
  localparam logic [2:0] PH_WASH    = 3'd1;
  localparam logic [2:0] PH_DRAIN_W = 3'd2;
  localparam logic [2:0] PH_SPIN    = 3'd3;
  localparam logic [2:0] PH_RINSE   = 3'd4;
  localparam logic [2:0] PH_DRAIN_R = 3'd5;
  localparam logic [2:0] PH_DONE    = 3'd6;
  localparam logic [2:0] PH_FSPIN   = 3'd7;

  localparam int MODE_WASH  = 0;
  localparam int MODE_RINSE = 1;
  localparam int MODE_FSPIN = 2;

  localparam int WALK_LEN = 6;

  function automatic logic phase_enabled(input logic [2:0] ph, input logic [2:0] m);
    logic en;
    en = 1'b0;
    case (ph)
      PH_WASH, PH_DRAIN_W, PH_SPIN: en = m[MODE_WASH];
      PH_RINSE, PH_DRAIN_R:         en = m[MODE_RINSE];
      PH_FSPIN:                     en = m[MODE_FSPIN];
      default:                      en = 1'b0;
    endcase
    return en;
  endfunction

  // Walk order positions 1..6 hold 1,2,3,4,5,7; DONE follows the last one.
  function automatic logic [2:0] walk_at(input int i);
    logic [2:0] ph;
    case (i)
      1:       ph = PH_WASH;
      2:       ph = PH_DRAIN_W;
      3:       ph = PH_SPIN;
      4:       ph = PH_RINSE;
      5:       ph = PH_DRAIN_R;
      6:       ph = PH_FSPIN;
      default: ph = PH_DONE;
    endcase
    return ph;
  endfunction

  function automatic int walk_pos(input logic [2:0] ph);
    int pos;
    case (ph)
      PH_WASH:    pos = 1;
      PH_DRAIN_W: pos = 2;
      PH_SPIN:    pos = 3;
      PH_RINSE:   pos = 4;
      PH_DRAIN_R: pos = 5;
      PH_FSPIN:   pos = 6;
      PH_DONE:    pos = 7;
      default:    pos = 0;
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/wash_phase_sequencer_tick_down_counter.sv
// Loadable down-counter that saturates at zero; isOne flags the final count
// so the owner can reload on the same edge the count would reach zero.
module tick_down_counter #(
  parameter int W = 8
) (
  input  logic         cp,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         isOne
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = loadVal;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge cp) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign isOne = (count_q == W'(1));

endmodule

// File: rtl/wash_phase_sequencer.sv
// Walks one wash program through its enabled phases, counting phase and
// whole-program time down on run-qualified ticks; phase is the exposed FSM state.
module wash_phase_sequencer
  import wash_phase_sequencer_pkg::*;
#(
  parameter int TW      = 8,
  parameter int TOTW    = 10,
  parameter int WASH_T  = 20,
  parameter int DRAIN_T = 5,
  parameter int SPIN_T  = 8,
  parameter int RINSE_T = 15,
  parameter int FSPIN_T = 10
) (
  input  logic            cp,
  input  logic            reset,
  input  logic            start,
  input  logic            run,
  input  logic            tick,
  input  logic [2:0]      mode,
  output logic [2:0]      phase,
  output logic [TW-1:0]   phaseLeft,
  output logic [TOTW-1:0] totalLeft,
  output logic            hadFinish,
  output logic            motorOn,
  output logic            drainOn
);

  function automatic logic [TW-1:0] phase_dur(input logic [2:0] ph);
    logic [TW-1:0] d;
    case (ph)
      PH_WASH:               d = TW'(WASH_T);
      PH_DRAIN_W, PH_DRAIN_R: d = TW'(DRAIN_T);
      PH_SPIN:               d = TW'(SPIN_T);
      PH_RINSE:              d = TW'(RINSE_T);
      PH_FSPIN:              d = TW'(FSPIN_T);
      default:               d = '0;
    endcase
    return d;
  endfunction

  // Scanning from the far end leaves the earliest enabled successor in n.
  function automatic logic [2:0] next_phase(input logic [2:0] p, input logic [2:0] m);
    logic [2:0] n;
    int         pos;
    n   = PH_DONE;
    pos = walk_pos(p);
    for (int i = WALK_LEN; i >= 1; i--) begin
      if ((i > pos) && phase_enabled(walk_at(i), m)) begin
        n = walk_at(i);
      end
    end
    return n;
  endfunction

  function automatic logic [TOTW-1:0] enabled_sum(input logic [2:0] m);
    logic [TOTW-1:0] s;
    s = '0;
    for (int i = 1; i <= WALK_LEN; i++) begin
      if (phase_enabled(walk_at(i), m)) begin
        s = s + TOTW'(phase_dur(walk_at(i)));
      end
    end
    return s;
  endfunction

  logic [2:0]      phase_q, phase_d;
  logic [2:0]      mode_q, mode_d;
  logic            hadfin_q, hadfin_d;
  logic            phase_active, start_ok, counted, phase_end;
  logic            pl_is_one, tot_is_one;
  logic [TW-1:0]   pl_count;
  logic [TOTW-1:0] tot_count;

  assign phase_active = (phase_q != PH_IDLE) && (phase_q != PH_DONE);
  assign start_ok     = start && !phase_active && (mode != 3'b000);
  assign counted      = tick && run && phase_active && !start_ok;
  assign phase_end    = counted && pl_is_one;

  always_comb begin
    phase_d = phase_q;
    mode_d  = mode_q;
    if (start_ok) begin
      mode_d  = mode;
      phase_d = next_phase(PH_IDLE, mode);
    end else if (phase_end) begin
      phase_d = next_phase(phase_q, mode_q);
    end
    hadfin_d = (phase_d == PH_DONE);
  end

  always_ff @(posedge cp) begin
    if (reset) begin
      phase_q  <= PH_IDLE;
      mode_q   <= 3'b000;
      hadfin_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      mode_q   <= mode_d;
      hadfin_q <= hadfin_d;
    end
  end

  // Reload value follows phase_d, so entering DONE loads zero.
  tick_down_counter #(.W(TW)) u_phase_timer (
    .cp      (cp),
    .reset   (reset),
    .load    (start_ok || phase_end),
    .loadVal (phase_dur(phase_d)),
    .en      (counted),
    .count   (pl_count),
    .isOne   (pl_is_one)
  );

  tick_down_counter #(.W(TOTW)) u_total_timer (
    .cp      (cp),
    .reset   (reset),
    .load    (start_ok),
    .loadVal (enabled_sum(mode)),
    .en      (counted),
    .count   (tot_count),
    .isOne   (tot_is_one)
  );

  // The two timers must expire together on the last counted tick.
  always_ff @(posedge cp) begin
    if (!reset && counted && (phase_d == PH_DONE)) begin
      assert (tot_is_one) else $error("total timer out of step with phase walk");
    end
  end

  assign phase     = phase_q;
  assign phaseLeft = pl_count;
  assign totalLeft = tot_count;
  assign hadFinish = hadfin_q;
  assign motorOn   = run && ((phase_q == PH_WASH) || (phase_q == PH_SPIN) ||
                             (phase_q == PH_RINSE) || (phase_q == PH_FSPIN));
  assign drainOn   = run && ((phase_q == PH_DRAIN_W) || (phase_q == PH_SPIN) ||
                             (phase_q == PH_DRAIN_R) || (phase_q == PH_FSPIN));

endmodule

// File: tb/tb_wash_phase_sequencer.sv
// Bench for wash_phase_sequencer: directed program walks plus random stimulus,
// checked every cycle against a phase-plan model through an expected-output queue.
module tb_wash_phase_sequencer;

  localparam int OW = 24;

  logic       cp = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       run = 1'b0;
  logic       tick = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [2:0] phase;
  logic [7:0] phaseLeft;
  logic [9:0] totalLeft;
  logic       hadFinish, motorOn, drainOn;

  int total_cnt = 0;
  int bad_cnt = 0;

  logic [OW-1:0] exp_q[$];

  int m_phase = 0;
  int m_left = 0;
  int m_total = 0;
  int m_plan[$];

  wash_phase_sequencer dut (
    .cp        (cp),
    .reset     (reset),
    .start     (start),
    .run       (run),
    .tick      (tick),
    .mode      (mode),
    .phase     (phase),
    .phaseLeft (phaseLeft),
    .totalLeft (totalLeft),
    .hadFinish (hadFinish),
    .motorOn   (motorOn),
    .drainOn   (drainOn)
  );

  // clock / reset
  always #5 cp = ~cp;

  function automatic int dur_of(input int ph);
    case (ph)
      1: return 20;
      2: return 5;
      3: return 8;
      4: return 15;
      5: return 5;
      7: return 10;
      default: return 0;
    endcase
  endfunction

  // Model: a program is a plan of phase codes consumed front to back.
  task automatic model_apply(input logic st, input logic rn, input logic tk,
                             input logic [2:0] md, input logic rs);
    if (rs) begin
      m_phase = 0; m_left = 0; m_total = 0;
      m_plan.delete();
    end else if (st && (m_phase == 0 || m_phase == 6) && md != 3'b000) begin
      m_plan.delete();
      if (md[0]) begin m_plan.push_back(1); m_plan.push_back(2); m_plan.push_back(3); end
      if (md[1]) begin m_plan.push_back(4); m_plan.push_back(5); end
      if (md[2]) m_plan.push_back(7);
      m_total = 0;
      foreach (m_plan[k]) m_total += dur_of(m_plan[k]);
      m_phase = m_plan.pop_front();
      m_left  = dur_of(m_phase);
    end else if (tk && rn && m_phase != 0 && m_phase != 6) begin
      m_total--;
      m_left--;
      if (m_left == 0) begin
        if (m_plan.size() > 0) begin
          m_phase = m_plan.pop_front();
          m_left  = dur_of(m_phase);
        end else begin
          m_phase = 6;
        end
      end
    end
  endtask

  // driver: inputs change at negedge, expected post-edge outputs are queued
  task automatic step(input logic st, input logic rn, input logic tk,
                      input logic [2:0] md, input logic rs);
    logic hf, mo, dr;
    @(negedge cp);
    reset = rs; start = st; run = rn; tick = tk; mode = md;
    model_apply(st, rn, tk, md, rs);
    hf = (m_phase == 6);
    mo = rn && (m_phase == 1 || m_phase == 3 || m_phase == 4 || m_phase == 7);
    dr = rn && (m_phase == 2 || m_phase == 3 || m_phase == 5 || m_phase == 7);
    exp_q.push_back({3'(m_phase), 8'(m_left), 10'(m_total), hf, mo, dr});
  endtask

  task automatic ticks(input int n, input logic [2:0] md);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, md, 1'b0);
  endtask

  task automatic check_now(input string name, input int ph, input int pl, input int tl,
                           input logic hf, input logic mo, input logic dr);
    @(posedge cp);
    #2;
    total_cnt++;
    if (phase !== 3'(ph) || phaseLeft !== 8'(pl) || totalLeft !== 10'(tl) ||
        hadFinish !== hf || motorOn !== mo || drainOn !== dr) begin
      bad_cnt++;
      $display("FAIL %s: got ph=%0d pl=%0d tl=%0d hf=%0b mo=%0b dr=%0b want ph=%0d pl=%0d tl=%0d hf=%0b mo=%0b dr=%0b",
               name, phase, phaseLeft, totalLeft, hadFinish, motorOn, drainOn,
               ph, pl, tl, hf, mo, dr);
    end
  endtask

  // scoreboard monitor: one queued expectation per driven edge
  always @(posedge cp) begin
    logic [OW-1:0] exp_v, act_v;
    #1;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      act_v = {phase, phaseLeft, totalLeft, hadFinish, motorOn, drainOn};
      total_cnt++;
      if (act_v !== exp_v) begin
        bad_cnt++;
        $display("FAIL out_vec t=%0t: got ph=%0d pl=%0d tl=%0d hf=%0b mo=%0b dr=%0b want ph=%0d pl=%0d tl=%0d hf=%0b mo=%0b dr=%0b",
                 $time, act_v[23:21], act_v[20:13], act_v[12:3], act_v[2], act_v[1], act_v[0],
                 exp_v[23:21], exp_v[20:13], exp_v[12:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  end

  initial begin
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    check_now("reset_state", 0, 0, 0, 1'b0, 1'b0, 1'b0);

    // full program
    step(1'b1, 1'b1, 1'b0, 3'b111, 1'b0);
    check_now("full_start", 1, 20, 63, 1'b0, 1'b1, 1'b0);
    ticks(62, 3'b111);
    check_now("full_last_tick", 7, 1, 1, 1'b0, 1'b1, 1'b1);
    ticks(1, 3'b111);
    check_now("full_done", 6, 0, 0, 1'b1, 1'b0, 1'b0);

    // rinse-only program
    step(1'b1, 1'b1, 1'b0, 3'b010, 1'b0);
    check_now("rinse_start", 4, 15, 20, 1'b0, 1'b1, 1'b0);
    ticks(15, 3'b010);
    check_now("rinse_drain", 5, 5, 5, 1'b0, 1'b0, 1'b1);
    ticks(5, 3'b010);
    check_now("rinse_done", 6, 0, 0, 1'b1, 1'b0, 1'b0);

    // restart from DONE with final-spin only
    step(1'b1, 1'b1, 1'b0, 3'b100, 1'b0);
    check_now("done_restart", 7, 10, 10, 1'b0, 1'b1, 1'b1);
    ticks(10, 3'b100);

    // pause mid-WASH
    step(1'b1, 1'b1, 1'b0, 3'b001, 1'b0);
    ticks(8, 3'b001);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 3'b001, 1'b0);
    check_now("pause_hold", 1, 12, 25, 1'b0, 1'b0, 1'b0);
    ticks(1, 3'b001);
    check_now("pause_resume", 1, 11, 24, 1'b0, 1'b1, 1'b0);

    // ignored starts and start+tick
    ticks(16, 3'b001);
    step(1'b1, 1'b1, 1'b0, 3'b111, 1'b0);
    check_now("start_mid_spin", 3, 8, 8, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 3'b000, 1'b1);
    step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    check_now("start_mode0", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 3'b001, 1'b0);
    check_now("start_with_tick", 1, 20, 33, 1'b0, 1'b1, 1'b0);

    // reset mid-RINSE with a tick
    step(1'b0, 1'b1, 1'b0, 3'b000, 1'b1);
    step(1'b1, 1'b1, 1'b0, 3'b011, 1'b0);
    ticks(36, 3'b011);
    check_now("rinse_mid", 4, 12, 17, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 3'b011, 1'b1);
    check_now("reset_mid_rinse", 0, 0, 0, 1'b0, 1'b0, 1'b0);

    // random stimulus
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 199) == 0));
    end
    step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);

    repeat (3) @(posedge cp);
    #3;
    total_cnt++;
    if (exp_q.size() != 0) begin
      bad_cnt++;
      $display("FAIL queue_drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
